// File: rtl/qam16_pkg.sv
// QAM16 shared definitions: Gray-coded constellation levels and the
// transmit FSM state encoding.
package qam16_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // 3-bit signed constellation levels
  localparam logic signed [2:0] LVL_M3 = 3'sb101;
  localparam logic signed [2:0] LVL_M1 = 3'sb111;
  localparam logic signed [2:0] LVL_P1 = 3'sb001;
  localparam logic signed [2:0] LVL_P3 = 3'sb011;

  // Gray map of one 2-bit field: 00->-3, 01->-1, 11->+1, 10->+3
  function automatic logic signed [2:0] gray2lvl(input logic [1:0] g);
    logic signed [2:0] lvl;
    case (g)
      2'b00:   lvl = LVL_M3;
      2'b01:   lvl = LVL_M1;
      2'b11:   lvl = LVL_P1;
      2'b10:   lvl = LVL_P3;
      default: lvl = LVL_M3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam16_iq_mixer.sv
// QAM16 I/Q mixer: registered products I*cos and Q*sin, then the registered
// difference I*cos - Q*sin. Valid and symbol-start flags travel alongside
// the data through the same two stages.
module qam16_iq_mixer #(
  parameter int MPR = 10,
  parameter int OW  = MPR + 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic signed [2:0]     i_lvl,
  input  logic signed [2:0]     q_lvl,
  input  logic                  iq_active,
  input  logic                  iq_load,
  input  logic signed [MPR-1:0] fcos_i,
  input  logic signed [MPR-1:0] fsin_i,
  output logic signed [OW-1:0]  tx_o,
  output logic                  out_valid,
  output logic                  sym_start
);

  // Products fit in MPR+2 signed bits (|3 * -512| = 1536), so the multiply
  // is carried out directly in that width.
  localparam int PW = MPR + 2;

  logic signed [PW-1:0] i_ext_s;
  logic signed [PW-1:0] q_ext_s;
  logic signed [PW-1:0] cos_ext_s;
  logic signed [PW-1:0] sin_ext_s;
  logic signed [PW-1:0] pi_s;
  logic signed [PW-1:0] pq_s;
  logic signed [PW-1:0] pi_r;
  logic signed [PW-1:0] pq_r;
  logic signed [OW-1:0] diff_s;
  logic                 v1_r;
  logic                 s1_r;

  assign i_ext_s   = PW'(i_lvl);
  assign q_ext_s   = PW'(q_lvl);
  assign cos_ext_s = PW'(fcos_i);
  assign sin_ext_s = PW'(fsin_i);
  assign pi_s      = i_ext_s * cos_ext_s;
  assign pq_s      = q_ext_s * sin_ext_s;
  assign diff_s    = OW'(pi_r) - OW'(pq_r);

  // Product stage: sample the carrier and multiply by the held levels
  always_ff @(posedge clk) begin
    if (reset) begin
      pi_r <= {PW{1'b0}};
      pq_r <= {PW{1'b0}};
      v1_r <= 1'b0;
      s1_r <= 1'b0;
    end else if (clken) begin
      pi_r <= pi_s;
      pq_r <= pq_s;
      v1_r <= iq_active;
      s1_r <= iq_load;
    end
  end

  // Sum stage: form the output sample and its flags
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_o      <= {OW{1'b0}};
      out_valid <= 1'b0;
      sym_start <= 1'b0;
    end else if (clken) begin
      tx_o      <= diff_s;
      out_valid <= v1_r;
      sym_start <= s1_r;
    end
  end

endmodule

// File: rtl/qam16_mod_tx.sv
// QAM16 transmit modulator top: symbol handshake, symbol-hold FSM and
// counter, Gray mapping into I/Q level registers, and the I/Q mixer.
module qam16_mod_tx
  import qam16_pkg::*;
#(
  parameter int MPR = 10,
  parameter int SPS = 8,
  parameter int OW  = MPR + 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic [3:0]            sym_i,
  input  logic                  sym_valid,
  output logic                  sym_ready,
  input  logic signed [MPR-1:0] fcos_i,
  input  logic signed [MPR-1:0] fsin_i,
  output logic signed [OW-1:0]  tx_o,
  output logic                  out_valid,
  output logic                  sym_start,
  output logic                  underrun
);

  localparam int            CW       = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic signed [2:0] i_r;
  logic signed [2:0] q_r;
  logic              load_r;
  logic              underrun_r;
  logic              last_s;
  logic              accept_s;

  // A new symbol can enter when idle or on the last sample of the current
  // one, which lets back-to-back symbols stream without a gap.
  assign last_s    = (cnt_r == CNT_LAST);
  assign sym_ready = clken & ((state_r == IDLE) | last_s);
  assign accept_s  = sym_valid & sym_ready;
  assign underrun  = underrun_r;

  // Symbol FSM: load levels on accept, count samples, flag underrun
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      i_r        <= 3'sb000;
      q_r        <= 3'sb000;
      load_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else if (clken) begin
      case (state_r)
        IDLE: begin
          underrun_r <= 1'b0;
          cnt_r      <= {CW{1'b0}};
          if (accept_s) begin
            i_r     <= gray2lvl(sym_i[3:2]);
            q_r     <= gray2lvl(sym_i[1:0]);
            load_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            i_r     <= 3'sb000;
            q_r     <= 3'sb000;
            load_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (last_s) begin
            cnt_r <= {CW{1'b0}};
            if (accept_s) begin
              i_r        <= gray2lvl(sym_i[3:2]);
              q_r        <= gray2lvl(sym_i[1:0]);
              load_r     <= 1'b1;
              underrun_r <= 1'b0;
              state_r    <= RUN;
            end else begin
              i_r        <= 3'sb000;
              q_r        <= 3'sb000;
              load_r     <= 1'b0;
              underrun_r <= 1'b1;
              state_r    <= IDLE;
            end
          end else begin
            cnt_r      <= cnt_r + CW'(1);
            load_r     <= 1'b0;
            underrun_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= {CW{1'b0}};
          i_r        <= 3'sb000;
          q_r        <= 3'sb000;
          load_r     <= 1'b0;
          underrun_r <= 1'b0;
        end
      endcase
    end
  end

  qam16_iq_mixer #(
    .MPR (MPR),
    .OW  (OW)
  ) u_mixer (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken),
    .i_lvl     (i_r),
    .q_lvl     (q_r),
    .iq_active (state_r == RUN),
    .iq_load   (load_r),
    .fcos_i    (fcos_i),
    .fsin_i    (fsin_i),
    .tx_o      (tx_o),
    .out_valid (out_valid),
    .sym_start (sym_start)
  );

endmodule

// File: tb/tb_qam16_mod_tx.sv
// Testbench for qam16_mod_tx: directed scenarios with literal expectations
// plus randomized traffic, all checked against a sample-level model.
module tb_qam16_mod_tx;

  localparam int MPR = 10;
  localparam int SPS = 8;
  localparam int OW  = MPR + 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  clken;
  logic [3:0]            sym_i;
  logic                  sym_valid;
  logic                  sym_ready;
  logic signed [MPR-1:0] fcos_i;
  logic signed [MPR-1:0] fsin_i;
  logic signed [OW-1:0]  tx_o;
  logic                  out_valid;
  logic                  sym_start;
  logic                  underrun;

  int total = 0;
  int bad   = 0;

  // Model: level lookup indexed by the 2-bit Gray field
  int lut [4] = '{-3, -1, 3, 1};
  // Model state: levels being played, samples still owed, first-sample flag
  int li = 0, lq = 0, rem = 0, act = 0, first = 0;
  // One product-stage sample in flight, then the expected outputs
  int p1 = 0, v1 = 0, s1 = 0;
  int etx = 0, eov = 0, ess = 0, eur = 0;

  qam16_mod_tx #(.MPR(MPR), .SPS(SPS), .OW(OW)) dut (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken),
    .sym_i     (sym_i),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .fcos_i    (fcos_i),
    .fsin_i    (fsin_i),
    .tx_o      (tx_o),
    .out_valid (out_valid),
    .sym_start (sym_start),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock: drive at negedge, check ready, advance model, check outputs
  task automatic cyc(input bit r, input bit ce, input bit sv, input logic [3:0] s,
                     input int c, input int sn);
    reset     = r;
    clken     = ce;
    sym_valid = sv;
    sym_i     = s;
    fcos_i    = 10'(c);
    fsin_i    = 10'(sn);
    #1;
    chk("sym_ready", int'(sym_ready), (ce && rem <= 1) ? 1 : 0);
    if (r) begin
      rem = 0; li = 0; lq = 0; act = 0; first = 0;
      p1 = 0; v1 = 0; s1 = 0;
      etx = 0; eov = 0; ess = 0; eur = 0;
    end else if (ce) begin
      etx = p1; eov = v1; ess = s1;
      p1 = li * c - lq * sn; v1 = act; s1 = first;
      if (rem <= 1 && sv) begin
        li = lut[s[3:2]]; lq = lut[s[1:0]];
        rem = SPS; act = 1; first = 1; eur = 0;
      end else if (rem == 1) begin
        li = 0; lq = 0; act = 0; rem = 0; first = 0; eur = 1;
      end else begin
        if (rem > 1) rem--;
        first = 0; eur = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("tx_o", int'(tx_o), etx);
    chk("out_valid", int'(out_valid), eov);
    chk("sym_start", int'(sym_start), ess);
    chk("underrun", int'(underrun), eur);
    @(negedge clk);
  endtask

  initial begin
    int n_hit, n_start, n_ur, n_val, first_v, last_v;
    reset = 1'b1; clken = 1'b1; sym_valid = 1'b0; sym_i = 4'd0;
    fcos_i = 10'sd0; fsin_i = 10'sd0;
    @(negedge clk);

    // 1: reset state
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 0, 0);
    chk("t1_tx", int'(tx_o), 0);
    chk("t1_valid", int'(out_valid), 0);
    chk("t1_underrun", int'(underrun), 0);
    chk("t1_ready", int'(sym_ready), 1);

    // 2: single symbol 1000 with full-scale cosine
    n_hit = 0; n_start = 0; n_ur = 0;
    cyc(1'b0, 1'b1, 1'b1, 4'b1000, 511, 0);
    for (int k = 1; k <= 14; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 4'b0000, 511, 0);
      if (out_valid && int'(tx_o) == 1533) n_hit++;
      if (sym_start) n_start++;
      if (underrun) n_ur++;
      if (k == 8)  chk("t2_underrun_edge", int'(underrun), 1);
      if (k == 9)  chk("t2_valid_before_fall", int'(out_valid), 1);
      if (k == 10) chk("t2_valid_fall", int'(out_valid), 0);
    end
    chk("t2_samples", n_hit, 8);
    chk("t2_starts", n_start, 1);
    chk("t2_underruns", n_ur, 1);

    // 3: back-to-back 0000 then 1111 with a negative sine
    n_hit = 0; n_start = 0; n_val = 0; first_v = -1; last_v = -1;
    cyc(1'b0, 1'b1, 1'b1, 4'b0000, 0, -512);
    for (int k = 1; k <= 24; k++) begin
      cyc(1'b0, 1'b1, (k <= 8) ? 1'b1 : 1'b0, 4'b1111, 0, -512);
      if (out_valid) begin
        n_val++;
        if (first_v < 0) first_v = k;
        last_v = k;
        if (n_val <= 8 && int'(tx_o) == -1536) n_hit++;
        if (n_val > 8 && int'(tx_o) == 512) n_hit++;
      end
      if (sym_start) n_start++;
    end
    chk("t3_values", n_hit, 16);
    chk("t3_span", last_v - first_v + 1, 16);
    chk("t3_valid_count", n_val, 16);
    chk("t3_starts", n_start, 2);

    // 4: extreme corner, no wrap
    n_hit = 0;
    cyc(1'b0, 1'b1, 1'b1, 4'b1010, -512, 511);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 4'b0000, -512, 511);
      if (out_valid && int'(tx_o) == -3069) n_hit++;
    end
    chk("t4_samples", n_hit, 8);

    // 5: clken alternating during a symbol
    n_hit = 0;
    cyc(1'b0, 1'b1, 1'b1, 4'b1000, 511, 0);
    for (int k = 0; k < 30; k++) begin
      cyc(1'b0, (k % 2) == 1, 1'b0, 4'b0000, 511, 0);
      if ((k % 2) == 1 && out_valid && int'(tx_o) == 1533) n_hit++;
      if ((k % 2) == 0) chk("t5_ready_low", int'(sym_ready), 0);
    end
    chk("t5_samples", n_hit, 8);

    // 6: reset at cnt=3, then normal latency
    cyc(1'b0, 1'b1, 1'b1, 4'b0101, 300, -200);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 4'b0000, 300, -200);
    cyc(1'b1, 1'b1, 1'b0, 4'b0000, 300, -200);
    chk("t6_tx", int'(tx_o), 0);
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_start", int'(sym_start), 0);
    chk("t6_underrun", int'(underrun), 0);
    n_ur = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 4'b0000, 300, -200);
      if (underrun) n_ur++;
    end
    chk("t6_no_underrun", n_ur, 0);
    cyc(1'b0, 1'b1, 1'b1, 4'b1101, 100, 50);
    chk("t6_lat1_valid", int'(out_valid), 0);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 100, 50);
    chk("t6_lat2_valid", int'(out_valid), 0);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 100, 50);
    chk("t6_lat3_valid", int'(out_valid), 1);
    chk("t6_lat3_start", int'(sym_start), 1);
    // 1101: I=+1, Q=-1; the product stage sampled cos=100, sin=50 -> 100+50
    chk("t6_lat3_tx", int'(tx_o), 150);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      cyc(($urandom_range(199) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
          ($urandom_range(9) < 7) ? 1'b1 : 1'b0,
          4'($urandom_range(15)),
          int'($urandom_range(1023)) - 512,
          int'($urandom_range(1023)) - 512);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
